// File: rtl/karatsuba_pkg.sv
// Shared definitions for the 8x8 Karatsuba issue stage: widths, defaults, FSM encoding.
package karatsuba_pkg;

  localparam int unsigned OP_W               = 8;
  localparam int unsigned PROD_W             = 16;
  localparam int unsigned TIMEOUT_DEFAULT    = 31;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RUN     = 2'd1;
  localparam state_t ST_RELEASE = 2'd2;

  typedef struct packed {
    logic [OP_W-1:0] x;
    logic [OP_W-1:0] y;
  } operand_t;

  // Counter/pointer width that stays at least one bit for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/karatsuba8_opfifo.sv
// Small operand FIFO of {x,y} pairs; push is ignored when full, pop ignored when empty.
module karatsuba8_opfifo
  import karatsuba_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  operand_t wdata,
  output operand_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PW = clog2_min1(DEPTH);
  localparam int unsigned CW = clog2_min1(DEPTH + 1);

  operand_t          mem_q [DEPTH];
  logic     [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic     [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic     [CW-1:0] count_q, count_d;
  logic              do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/karatsuba8_issue.sv
// Issue stage in front of the Karatsuba control unit: buffers operand pairs, sequences
// core_start/core_done handshakes with a timeout, and holds products for the consumer.
module karatsuba8_issue
  import karatsuba_pkg::*;
#(
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_x,
  input  logic [OP_W-1:0]   in_y,
  output logic              core_start,
  output logic [OP_W-1:0]   core_x,
  output logic [OP_W-1:0]   core_y,
  input  logic              core_done,
  input  logic [PROD_W-1:0] core_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_p,
  output logic              err,
  output logic [7:0]        done_cnt,
  output logic              busy
);

  localparam int unsigned TW = clog2_min1(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   core_x_q, core_x_d;
  logic [OP_W-1:0]   core_y_q, core_y_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              out_valid_q, out_valid_d;
  logic [PROD_W-1:0] out_p_q, out_p_d;
  logic              err_q, err_d;
  logic [7:0]        done_cnt_q, done_cnt_d;

  logic              fifo_pop, fifo_full, fifo_empty;
  operand_t          fifo_head, fifo_wdata;
  logic              out_accept, capture, abort;

  assign fifo_wdata = '{x: in_x, y: in_y};

  karatsuba8_opfifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_opfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_accept = out_valid_q && out_ready;

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    fifo_pop = 1'b0;
    capture  = 1'b0;
    abort    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Issue only when the output slot is free now or is being drained this cycle.
        if (!fifo_empty && (!out_valid_q || out_accept)) begin
          fifo_pop = 1'b1;
          tcnt_d   = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (core_done) begin
          capture = 1'b1;
          state_d = ST_RELEASE;
        end else if (tcnt_q == TW'(TIMEOUT)) begin
          abort   = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    core_x_d    = core_x_q;
    core_y_d    = core_y_q;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    done_cnt_d  = done_cnt_q;
    err_d       = err_q | abort;
    if (fifo_pop) begin
      core_x_d = fifo_head.x;
      core_y_d = fifo_head.y;
    end
    if (out_accept) begin
      out_valid_d = 1'b0;
      done_cnt_d  = done_cnt_q + 8'd1;
    end
    if (capture) begin
      out_valid_d = 1'b1;
      out_p_d     = core_p;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      core_x_q    <= '0;
      core_y_q    <= '0;
      tcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      err_q       <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      core_x_q    <= core_x_d;
      core_y_q    <= core_y_d;
      tcnt_q      <= tcnt_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      err_q       <= err_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign in_ready   = !fifo_full;
  assign core_start = (state_q == ST_RUN);
  assign core_x     = core_x_q;
  assign core_y     = core_y_q;
  assign out_valid  = out_valid_q;
  assign out_p      = out_p_q;
  assign err        = err_q;
  assign done_cnt   = done_cnt_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_karatsuba8_issue.sv
// Bench for karatsuba8_issue: stub core with programmable latency, product scoreboard queue.
module tb_karatsuba8_issue;

  localparam int unsigned TIMEOUT    = 31;
  localparam int unsigned FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x, in_y;
  logic        core_start;
  logic [7:0]  core_x, core_y;
  logic        core_done;
  logic [15:0] core_p;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic        err;
  logic [7:0]  done_cnt;
  logic        busy;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];
  int          exp_done, run_len, low_len, last_run, last_gap, n_runs;

  // Stub core: done on the stub_lat-th consecutive start cycle; stub_lat == 0 never finishes.
  int          stub_lat;
  int          stub_cnt;
  logic        stray_done;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst || !core_start) stub_cnt <= 0;
    else                    stub_cnt <= stub_cnt + 1;
  end

  assign core_done = stray_done | (core_start && (stub_lat > 0) && (stub_cnt == stub_lat - 1));
  assign core_p    = {8'd0, core_x} * {8'd0, core_y};

  karatsuba8_issue #(
    .TIMEOUT    (TIMEOUT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .core_start (core_start),
    .core_x     (core_x),
    .core_y     (core_y),
    .core_done  (core_done),
    .core_p     (core_p),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_p      (out_p),
    .err        (err),
    .done_cnt   (done_cnt),
    .busy       (busy)
  );

  // One clock: observe at the falling edge (scoreboard pop, start-pulse tracking),
  // then return just after the next rising edge.
  task automatic step();
    logic [15:0] want;
    @(negedge clk);
    if (core_start) begin
      if (run_len == 0) last_gap = low_len;
      run_len++;
      low_len = 0;
    end else begin
      if (run_len != 0) begin
        last_run = run_len;
        n_runs++;
      end
      run_len = 0;
      low_len++;
    end
    if (!rst && out_valid && out_ready) begin
      vectors++;
      exp_done++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_product got=%0d want=none", out_p);
      end else begin
        want = exp_q.pop_front();
        if (out_p !== want) begin
          miscompares++;
          $display("FAIL product got=%0d want=%0d", out_p, want);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [7:0] x, input logic [7:0] y, input bit exp_out);
    bit accepted;
    int n;
    accepted = 1'b0;
    n        = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    while (!accepted && n < 200) begin
      accepted = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout got=not_accepted want=accepted x=%0d y=%0d", x, y);
    end else if (exp_out) begin
      exp_q.push_back({8'd0, x} * {8'd0, y});
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL drain got=pending%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_x       = '0;
    in_y       = '0;
    out_ready  = 1'b0;
    stray_done = 1'b0;
    stub_lat   = 0;
    exp_done   = 0;
    run_len    = 0;
    low_len    = 0;
    last_run   = 0;
    last_gap   = 0;
    n_runs     = 0;
    step();
    step();
    vectors++;
    if ({in_ready, core_start, out_valid, err, busy} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_flags got=%b want=10000", {in_ready, core_start, out_valid, err, busy});
    end
    vectors++;
    if ({core_x, core_y} !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_core_xy got=%0d,%0d want=0,0", core_x, core_y);
    end
    vectors++;
    if (out_p !== 16'd0 || done_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_out got=p%0d,cnt%0d want=p0,cnt0", out_p, done_cnt);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int n;
    stub_lat  = 10;
    out_ready = 1'b1;
    push_op(8'd13, 8'd11, 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    vectors++;
    if (out_p !== 16'd143) begin
      miscompares++;
      $display("FAIL single_out_p got=%0d want=143", out_p);
    end
    drain(20);
    step();
    vectors++;
    if (last_run !== 10) begin
      miscompares++;
      $display("FAIL single_start_len got=%0d want=10", last_run);
    end
    vectors++;
    if (done_cnt !== 8'd1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_cnt_busy got=%0d,%b want=1,0", done_cnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0        = n_runs;
    stub_lat  = 4;
    out_ready = 1'b1;
    push_op(8'd255, 8'd255, 1'b1);
    push_op(8'd0, 8'd7, 1'b1);
    push_op(8'd16, 8'd16, 1'b1);
    vectors++;
    if (in_ready !== 1'b0 || core_start !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_full got=rdy%b,start%b want=rdy0,start1", in_ready, core_start);
    end
    // Offered while full: must wait and come out after (16,16).
    push_op(8'd200, 8'd3, 1'b1);
    drain(100);
    step();
    vectors++;
    if (n_runs - n0 !== 4 || last_run !== 4) begin
      miscompares++;
      $display("FAIL b2b_runs got=%0d,len%0d want=4,len4", n_runs - n0, last_run);
    end
    // Low gap between ops is the RELEASE cycle plus the IDLE issue cycle.
    vectors++;
    if (last_gap !== 2) begin
      miscompares++;
      $display("FAIL b2b_gap got=%0d want=2", last_gap);
    end
    vectors++;
    if (done_cnt !== 8'(exp_done)) begin
      miscompares++;
      $display("FAIL b2b_done_cnt got=%0d want=%0d", done_cnt, 8'(exp_done));
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    bit          stable;
    int          n;
    stub_lat  = 3;
    out_ready = 1'b0;
    push_op(8'd3, 8'd5, 1'b1);
    push_op(8'd7, 8'd9, 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    held   = out_p;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_p !== held || out_valid !== 1'b1 || core_start !== 1'b0) stable = 1'b0;
    end
    vectors++;
    if (held !== 16'd15) begin
      miscompares++;
      $display("FAIL bp_first got=%0d want=15", held);
    end
    vectors++;
    if (!stable) begin
      miscompares++;
      $display("FAIL bp_hold got=changed want=held_no_issue p=%0d", out_p);
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if (core_start !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_reissue got=start%b,valid%b want=start1,valid0", core_start, out_valid);
    end
    drain(40);
  endtask

  task automatic test_timeout();
    int n;
    stub_lat  = 0;
    out_ready = 1'b1;
    push_op(8'd2, 8'd3, 1'b0);
    push_op(8'd4, 8'd5, 1'b1);
    n = 0;
    while (!err && n < 80) begin
      step();
      n++;
    end
    stub_lat = 5;
    vectors++;
    if (err !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_err got=err%b,valid%b want=err1,valid0", err, out_valid);
    end
    step();
    // Counter runs 0..TIMEOUT in RUN before the abort.
    vectors++;
    if (last_run !== TIMEOUT + 1) begin
      miscompares++;
      $display("FAIL timeout_len got=%0d want=%0d", last_run, TIMEOUT + 1);
    end
    drain(60);
    vectors++;
    if (err !== 1'b1 || done_cnt !== 8'(exp_done)) begin
      miscompares++;
      $display("FAIL timeout_after got=err%b,cnt%0d want=err1,cnt%0d", err, done_cnt,
               8'(exp_done));
    end
  endtask

  task automatic test_stray_done();
    stray_done = 1'b1;
    for (int i = 0; i < 3; i++) step();
    stray_done = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0 || core_start !== 1'b0 || busy !== 1'b0 ||
        done_cnt !== 8'(exp_done)) begin
      miscompares++;
      $display("FAIL stray_done got=valid%b,start%b,busy%b,cnt%0d want=0,0,0,%0d", out_valid,
               core_start, busy, done_cnt, 8'(exp_done));
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    stub_lat  = 0;
    out_ready = 1'b1;
    push_op(8'd9, 8'd9, 1'b0);
    n = 0;
    while (!core_start && n < 10) begin
      step();
      n++;
    end
    push_op(8'd1, 8'd1, 1'b0);
    push_op(8'd2, 8'd2, 1'b0);
    vectors++;
    if (in_ready !== 1'b0 || core_start !== 1'b1) begin
      miscompares++;
      $display("FAIL rmr_pre got=rdy%b,start%b want=rdy0,start1", in_ready, core_start);
    end
    rst = 1'b1;
    step();
    vectors++;
    if ({core_start, in_ready, out_valid, err, busy} !== 5'b01000 || done_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL rmr_after got=%b,cnt%0d want=01000,cnt0",
               {core_start, in_ready, out_valid, err, busy}, done_cnt);
    end
    rst = 1'b0;
    exp_q.delete();
    exp_done = 0;
    stub_lat = 2;
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (core_start !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rmr_discard got=start%b,busy%b,valid%b want=0,0,0", core_start, busy,
               out_valid);
    end
  endtask

  task automatic test_wrap();
    stub_lat  = 1;
    out_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      push_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
    end
    drain(1000);
    vectors++;
    if (done_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL wrap_255 got=%0d want=255", done_cnt);
    end
    push_op(8'd255, 8'd1, 1'b1);
    drain(20);
    vectors++;
    if (done_cnt !== 8'd0 || exp_done !== 256) begin
      miscompares++;
      $display("FAIL wrap_0 got=%0d,handshakes%0d want=0,handshakes256", done_cnt, exp_done);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=stuck want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_stray_done();
    test_reset_mid_run();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
